// File: rtl/text_pkg.sv
// Shared definitions for the text RAM boot loader: flash command, RAM address width,
// loader FSM encoding and the flash address byte selector.
package text_pkg;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam int         TEXT_AW        = 15;
    localparam logic [1:0] ADDR_LAST_IDX  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEL    = 3'd1,
        ST_CMD    = 3'd2,
        ST_ADDR   = 3'd3,
        ST_DATA   = 3'd4,
        ST_FINISH = 3'd5
    } ldr_state_e;

    // Byte to queue behind address byte idx: the top byte goes out with the command.
    function automatic logic [7:0] addr_byte(input logic [23:0] base, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = base[15:8];
            2'd1:    b = base[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/flash_spi_shifter.sv
// SPI mode-0 bit engine: SCK half-period divider plus an 8-bit MSB-first transmit
// shifter and receive shifter. The owner supplies the next byte at each byte boundary.
module flash_spi_shifter #(
    parameter int SCK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       load,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       byte_end,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);

    localparam int               DIV_W    = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);

    logic [DIV_W-1:0] div_r;
    logic             sck_r;
    logic [7:0]       tx_r;
    logic [6:0]       rx_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       rx_byte_r;
    logic             byte_done_r;
    logic             tick_s;
    logic             rise_s;
    logic             fall_s;

    assign tick_s    = run & (div_r == DIV_LAST);
    assign rise_s    = tick_s & ~sck_r;
    assign fall_s    = tick_s & sck_r;
    // bit_cnt wraps to 0 after the 8th rise, so this falling edge closes a byte
    assign byte_end  = fall_s & (bit_cnt_r == 3'd0);
    assign sck       = sck_r;
    assign mosi      = tx_r[7];
    assign rx_byte   = rx_byte_r;
    assign byte_done = byte_done_r;

    // divider, clock phase and both shift registers
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r       <= {DIV_W{1'b0}};
            sck_r       <= 1'b0;
            tx_r        <= 8'h00;
            rx_r        <= 7'h00;
            bit_cnt_r   <= 3'd0;
            rx_byte_r   <= 8'h00;
            byte_done_r <= 1'b0;
        end else if (load) begin
            div_r       <= {DIV_W{1'b0}};
            sck_r       <= 1'b0;
            tx_r        <= tx_byte;
            rx_r        <= 7'h00;
            bit_cnt_r   <= 3'd0;
            byte_done_r <= 1'b0;
        end else if (!run) begin
            div_r       <= {DIV_W{1'b0}};
            sck_r       <= 1'b0;
            byte_done_r <= 1'b0;
        end else begin
            byte_done_r <= 1'b0;
            if (tick_s) begin
                div_r <= {DIV_W{1'b0}};
                sck_r <= ~sck_r;
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
            if (rise_s) begin
                rx_r      <= {rx_r[5:0], miso};
                bit_cnt_r <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                    rx_byte_r   <= {rx_r, miso};
                    byte_done_r <= 1'b1;
                end
            end
            if (fall_s) begin
                tx_r <= (bit_cnt_r == 3'd0) ? tx_byte : {tx_r[6:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/flash_text_loader.sv
// Boot loader for the text RAM: streams LOAD_BYTES from SPI flash (read command) into
// RAM 0..N-1 and otherwise passes host writes straight through to the RAM write port.
module flash_text_loader
    import text_pkg::*;
#(
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter int          LOAD_BYTES = 32768,
    parameter int          SCK_DIV    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               host_drop,
    output logic               flash_sck,
    output logic               flash_mosi,
    output logic               flash_ssel,
    input  logic               flash_miso,
    input  logic               host_write,
    input  logic [TEXT_AW-1:0] host_addr,
    input  logic [7:0]         host_d,
    output logic               ram_write,
    output logic [TEXT_AW-1:0] ram_addr,
    output logic [7:0]         ram_d
);

    localparam int               DIV_W    = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
    localparam logic [15:0]      LOAD_CNT = 16'(LOAD_BYTES);

    ldr_state_e       state_r, state_nx;
    logic [DIV_W-1:0] wait_r, wait_nx;
    logic [1:0]       idx_r, idx_nx;
    logic [15:0]      byte_count_r, byte_count_nx;
    logic             busy_r, busy_nx;
    logic             done_r, done_nx;
    logic             ssel_r, ssel_nx;
    logic             sh_run_s;
    logic             sh_load_s;
    logic [7:0]       tx_byte_s;
    logic [7:0]       rx_byte_s;
    logic             byte_done_s;
    logic             byte_end_s;
    logic             ld_write_s;

    flash_spi_shifter #(.SCK_DIV(SCK_DIV)) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .run       (sh_run_s),
        .load      (sh_load_s),
        .tx_byte   (tx_byte_s),
        .rx_byte   (rx_byte_s),
        .byte_done (byte_done_s),
        .byte_end  (byte_end_s),
        .sck       (flash_sck),
        .mosi      (flash_mosi),
        .miso      (flash_miso)
    );

    // loader state and control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            wait_r       <= {DIV_W{1'b0}};
            idx_r        <= 2'd0;
            byte_count_r <= 16'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            ssel_r       <= 1'b1;
        end else begin
            state_r      <= state_nx;
            wait_r       <= wait_nx;
            idx_r        <= idx_nx;
            byte_count_r <= byte_count_nx;
            busy_r       <= busy_nx;
            done_r       <= done_nx;
            ssel_r       <= ssel_nx;
        end
    end

    // next-state logic and shifter sequencing
    always_comb begin
        state_nx      = state_r;
        wait_nx       = wait_r;
        idx_nx        = idx_r;
        byte_count_nx = byte_count_r;
        busy_nx       = busy_r;
        done_nx       = done_r;
        ssel_nx       = ssel_r;
        sh_run_s      = 1'b0;
        sh_load_s     = 1'b0;
        tx_byte_s     = 8'h00;
        ld_write_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                tx_byte_s = FLASH_CMD_READ;
                if (start) begin
                    state_nx      = ST_SEL;
                    sh_load_s     = 1'b1;
                    busy_nx       = 1'b1;
                    done_nx       = 1'b0;
                    ssel_nx       = 1'b0;
                    wait_nx       = {DIV_W{1'b0}};
                    idx_nx        = 2'd0;
                    byte_count_nx = 16'd0;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SEL: begin
                if (wait_r == DIV_LAST) begin
                    state_nx = ST_CMD;
                    wait_nx  = {DIV_W{1'b0}};
                end else begin
                    wait_nx = wait_r + DIV_W'(1);
                end
            end
            ST_CMD: begin
                sh_run_s  = 1'b1;
                tx_byte_s = FLASH_BASE[23:16];
                if (byte_end_s) begin
                    state_nx = ST_ADDR;
                end else begin
                    state_nx = ST_CMD;
                end
            end
            ST_ADDR: begin
                sh_run_s  = 1'b1;
                tx_byte_s = addr_byte(FLASH_BASE, idx_r);
                if (byte_end_s && (idx_r == ADDR_LAST_IDX)) begin
                    state_nx = ST_DATA;
                    idx_nx   = 2'd0;
                end else if (byte_end_s) begin
                    idx_nx = idx_r + 2'd1;
                end else begin
                    idx_nx = idx_r;
                end
            end
            ST_DATA: begin
                sh_run_s   = 1'b1;
                ld_write_s = byte_done_s;
                if (byte_done_s) begin
                    byte_count_nx = byte_count_r + 16'd1;
                end else begin
                    byte_count_nx = byte_count_r;
                end
                // with SCK_DIV=1 the last byte's write and its closing fall share a cycle
                if (byte_end_s && ((byte_count_r + {15'd0, byte_done_s}) == LOAD_CNT)) begin
                    state_nx = ST_FINISH;
                    wait_nx  = {DIV_W{1'b0}};
                end else begin
                    state_nx = ST_DATA;
                end
            end
            ST_FINISH: begin
                if (wait_r == DIV_LAST) begin
                    state_nx = ST_IDLE;
                    wait_nx  = {DIV_W{1'b0}};
                    ssel_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end else begin
                    wait_nx = wait_r + DIV_W'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
                busy_nx  = 1'b0;
                ssel_nx  = 1'b1;
            end
        endcase
    end

    // write-port arbitration: host owns the port whenever no load is running
    always_comb begin
        if (busy_r) begin
            ram_write = ld_write_s;
            ram_addr  = byte_count_r[TEXT_AW-1:0];
            ram_d     = rx_byte_s;
        end else begin
            ram_write = host_write;
            ram_addr  = host_addr;
            ram_d     = host_d;
        end
    end

    assign host_drop  = busy_r & host_write;
    assign busy       = busy_r;
    assign done       = done_r;
    assign flash_ssel = ssel_r;

endmodule

// File: tb/tb_flash_text_loader.sv
// Scoreboard bench for flash_text_loader: a flash model on the SPI pins, expected RAM
// writes queued by the stimulus and popped by an independent monitor.
module tb_flash_text_loader;

    localparam int          N        = 4;
    localparam int          S        = 2;
    localparam logic [23:0] BASE     = 24'h012345;
    localparam int          BITS     = 32 + 8 * N;
    localparam int          LOAD_CYC = 2 * S * BITS + 2 * S + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, host_drop;
    logic        flash_sck, flash_mosi, flash_ssel;
    logic        flash_miso = 1'b0;
    logic        host_write = 1'b0;
    logic [14:0] host_addr = 15'h0000;
    logic [7:0]  host_d = 8'h00;
    logic        ram_write;
    logic [14:0] ram_addr;
    logic [7:0]  ram_d;

    flash_text_loader #(.FLASH_BASE(BASE), .LOAD_BYTES(N), .SCK_DIV(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .host_drop  (host_drop),
        .flash_sck  (flash_sck),
        .flash_mosi (flash_mosi),
        .flash_ssel (flash_ssel),
        .flash_miso (flash_miso),
        .host_write (host_write),
        .host_addr  (host_addr),
        .host_d     (host_d),
        .ram_write  (ram_write),
        .ram_addr   (ram_addr),
        .ram_d      (ram_d)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]  flash_data [0:3] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    logic [22:0] exp_q [$];

    logic        prev_sck  = 1'b0;
    logic        prev_ssel = 1'b1;
    logic        prev_mosi = 1'b0;
    int          rise_cnt  = 0;
    logic [31:0] mosi_cap  = 32'h0;
    int          mosi_bad  = 0;
    int          drop_cnt  = 0;
    int          wr_seen   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: scoreboard pop, flash model, MOSI capture at SCK rises
    always @(negedge clk) begin
        logic [22:0] e;
        if (ram_write) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ram_write: got addr %0h d %0h expected no write", ram_addr, ram_d);
            end else begin
                e = exp_q.pop_front();
                check("ram_addr", {17'h0, ram_addr}, {17'h0, e[22:8]});
                check("ram_d", {24'h0, ram_d}, {24'h0, e[7:0]});
            end
        end
        if (host_drop) drop_cnt++;
        if (flash_ssel) begin
            rise_cnt   = 0;
            flash_miso = 1'b0;
        end else begin
            if (prev_ssel) begin
                mosi_cap = 32'h0;
                mosi_bad = 0;
            end
            if (!prev_sck && flash_sck) begin
                if (flash_mosi !== prev_mosi) mosi_bad++;
                if (rise_cnt < 32) mosi_cap = {mosi_cap[30:0], flash_mosi};
                else if (flash_mosi !== 1'b0) mosi_bad++;
                rise_cnt++;
            end
            if (prev_sck && !flash_sck) begin
                if (rise_cnt >= 32 && rise_cnt < BITS)
                    flash_miso = flash_data[(rise_cnt - 32) / 8][7 - ((rise_cnt - 32) % 8)];
                else
                    flash_miso = 1'b1;
            end
        end
        prev_sck  = flash_sck;
        prev_ssel = flash_ssel;
        prev_mosi = flash_mosi;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic full_load(input string tag, input bit host_same, input bit mid_events);
        int cyc;
        int drops0;
        drops0 = drop_cnt;
        if (host_same) begin
            host_write = 1'b1;
            host_addr  = 15'h0777;
            host_d     = 8'h5A;
            exp_q.push_back({15'h0777, 8'h5A});
        end
        for (int i = 0; i < N; i++) exp_q.push_back({15'(i), flash_data[i]});
        start = 1'b1;
        tick();
        start      = 1'b0;
        host_write = 1'b0;
        cyc        = 1;
        check({tag, "_busy_rise"}, {31'h0, busy}, 32'h1);
        check({tag, "_done_clear"}, {31'h0, done}, 32'h0);
        check({tag, "_ssel_low"}, {31'h0, flash_ssel}, 32'h0);
        while (!done && cyc < 2 * LOAD_CYC) begin
            if (mid_events && cyc == 150) begin
                start      = 1'b1;
                host_write = 1'b1;
                host_addr  = 15'h0100;
                host_d     = 8'hEE;
            end
            tick();
            cyc++;
            start      = 1'b0;
            host_write = 1'b0;
        end
        check({tag, "_load_cycles"}, cyc, LOAD_CYC);
        check({tag, "_done"}, {31'h0, done}, 32'h1);
        check({tag, "_ssel_end"}, {31'h0, flash_ssel}, 32'h1);
        check({tag, "_busy_end"}, {31'h0, busy}, 32'h0);
        check({tag, "_mosi_cmd_addr"}, mosi_cap, 32'h03012345);
        check({tag, "_mosi_stable"}, mosi_bad, 0);
        check({tag, "_host_drops"}, drop_cnt - drops0, mid_events ? 1 : 0);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_drop", {31'h0, host_drop}, 32'h0);
        check("rst_sck", {31'h0, flash_sck}, 32'h0);
        check("rst_mosi", {31'h0, flash_mosi}, 32'h0);
        check("rst_ssel", {31'h0, flash_ssel}, 32'h1);
        check("rst_ram_write", {31'h0, ram_write}, 32'h0);
        rst = 1'b0;
        tick();

        // idle host write passes through combinationally
        host_write = 1'b1;
        host_addr  = 15'h1234;
        host_d     = 8'h41;
        exp_q.push_back({15'h1234, 8'h41});
        #1;
        check("host_pass_write", {31'h0, ram_write}, 32'h1);
        check("host_pass_addr", {17'h0, ram_addr}, 32'h1234);
        check("host_pass_d", {24'h0, ram_d}, 32'h41);
        check("host_pass_drop", {31'h0, host_drop}, 32'h0);
        tick();
        host_write = 1'b0;
        tick();

        full_load("load1", 1'b0, 1'b1);
        tick();
        full_load("load2", 1'b1, 1'b0);
        tick();

        // reset after two bytes have landed
        exp_q.push_back({15'h0000, 8'hA5});
        exp_q.push_back({15'h0001, 8'h3C});
        guard = wr_seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2 * LOAD_CYC && wr_seen < guard + 2; i++) tick();
        check("rst_mid_writes", wr_seen - guard, 2);
        rst = 1'b1;
        tick();
        check("rst_mid_ssel", {31'h0, flash_ssel}, 32'h1);
        check("rst_mid_busy", {31'h0, busy}, 32'h0);
        check("rst_mid_done", {31'h0, done}, 32'h0);
        check("rst_mid_sck", {31'h0, flash_sck}, 32'h0);
        rst = 1'b0;
        repeat (2) tick();
        check("rst_mid_sb_empty", exp_q.size(), 0);

        full_load("load3", 1'b0, 1'b0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
